// File: rtl/fetch_phase_sequencer.sv
// Fetch/execute sequencer feeding the decode ROM: PC, fetch register, phase bit and C/Z flags.
// The decode address is formed only from registers, so the ROM never sees a combinational input path.
module fetch_phase_sequencer #(
  parameter int PC_W   = 12,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WORD_W-1:0] prog_byte,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic [PC_W-1:0]   load_addr,
  input  logic              load_flags,
  input  logic              alu_c,
  input  logic              alu_z,
  output logic [PC_W-1:0]   prog_addr,
  output logic [3:0]        opcode,
  output logic [3:0]        oprnd,
  output logic              c_flag,
  output logic              z_flag,
  output logic              phase,
  output logic [6:0]        dec_addr
);

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} phase_e;

  phase_e            phase_q, phase_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [3:0]        oprnd_q, oprnd_d;
  logic              c_q, c_d;
  logic              z_q, z_d;

  always_comb begin
    phase_d  = phase_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    oprnd_d  = oprnd_q;
    c_d      = c_q;
    z_d      = z_q;
    if (enable) begin
      // Latch the instruction only on the fetch edge so EXEC decodes a stable word.
      if (phase_q == FETCH) begin
        opcode_d = prog_byte[WORD_W-1 -: 4];
        oprnd_d  = prog_byte[3:0];
        phase_d  = EXEC;
      end else begin
        phase_d  = FETCH;
      end
      // Jump beats increment; PC wraps naturally at 2^PC_W.
      if (load_pc)     pc_d = load_addr;
      else if (inc_pc) pc_d = pc_q + 1'b1;
      if (load_flags) begin
        c_d = alu_c;
        z_d = alu_z;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= FETCH;
      pc_q     <= '0;
      opcode_q <= '0;
      oprnd_q  <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      oprnd_q  <= oprnd_d;
      c_q      <= c_d;
      z_q      <= z_d;
    end
  end

  assign prog_addr = pc_q;
  assign opcode    = opcode_q;
  assign oprnd     = oprnd_q;
  assign c_flag    = c_q;
  assign z_flag    = z_q;
  assign phase     = phase_q;
  assign dec_addr  = {opcode_q, c_q, z_q, phase_q};

endmodule

// File: doc/fetch_phase_sequencer.md
Name: fetch_phase_sequencer

Overview:
- Upstream stage of the 7-bit-address / 13-bit-control-word decode ROM in the 4-bit processor datapath.
- Holds the program counter, fetch register, phase flip-flop and C/Z flag register.
- Its sole product for the decoder is the 7-bit address {opcode[3:0], C, Z, phase}.
- Consumes the decoder's PC-control and flag-load lines, so PC, phase and flags advance in lockstep with the control word.

Parameters:
PC_W, 12, program counter / program memory address width
WORD_W, 8, program memory word width (opcode nibble + operand nibble)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
enable  input  1  global step enable; when 0 all registers hold
prog_byte  input  WORD_W  program memory data at prog_addr, combinational read
inc_pc  input  1  decoder control: increment PC
load_pc  input  1  decoder control: load PC from load_addr
load_addr  input  PC_W  jump target from datapath ({oprnd, prog_byte})
load_flags  input  1  decoder control: capture alu_c/alu_z
alu_c  input  1  ALU carry out
alu_z  input  1  ALU zero result
prog_addr  output  PC_W  current PC, drives program memory
opcode  output  4  fetched instruction high nibble
oprnd  output  4  fetched instruction low nibble
c_flag  output  1  registered carry flag
z_flag  output  1  registered zero flag
phase  output  1  0 = fetch cycle, 1 = execute cycle
dec_addr  output  7  {opcode, c_flag, z_flag, phase}, to decode ROM

Behaviour:
- One clock; reset is asynchronous and active-high; all state updates on rising clk edge.
- Reset (async, any time, including mid-instruction):
  - prog_addr=0, opcode=0, oprnd=0, c_flag=0, z_flag=0, phase=0, so dec_addr=7'b0000000.
  - Deasserting reset resumes at the fetch phase of address 0.
- enable=0: every register holds; control inputs are ignored.
- Phase FSM, 2 states:
  - FETCH(0) -> EXEC(1) -> FETCH on each enabled edge.
  - No other transitions.
- Fetch register:
  - On an enabled edge with phase=0, opcode<=prog_byte[7:4] and oprnd<=prog_byte[3:0].
  - Holds during phase=1, so EXEC decodes a stable instruction.
- Program counter (enabled edges only):
  - load_pc=1: PC<=load_addr.
  - else inc_pc=1: PC<=PC+1, modulo 2^PC_W; 0xFFF wraps to 0x000, no flag.
  - else hold.
  - load_pc and inc_pc both 1: load wins, no increment.
  - PC control is honoured in either phase; the decoder decides which.
- Flags: on an enabled edge with load_flags=1, c_flag<=alu_c and z_flag<=alu_z; otherwise hold. Not phase-gated.
- dec_addr is purely combinational from registers: no combinational path from any input.
  - Latency: a new opcode reaches dec_addr 1 cycle after the fetch edge.
  - Flag update reaches dec_addr 1 cycle after the load_flags edge.
- Simultaneous events:
  - load_flags on the same edge as phase 1->0: new flags and phase 0 appear together.
  - Fetch latch and PC increment on the same edge: the fetch uses the pre-edge prog_byte.
- No X-propagation: all registers have reset values; no latches.

Test Plan:
1. Assert reset mid-EXEC with PC=0x123, C=Z=1 -> outputs go to 0 immediately (before the next edge); dec_addr=0000000.
2. prog_byte=0x5A, enable=1, inc_pc=1 on the fetch edge -> opcode=5, oprnd=A, phase=1, prog_addr=0x001, dec_addr=0101001; next edge -> phase=0, dec_addr=0101000.
3. PC=0xFFF, inc_pc=1 -> prog_addr=0x000; repeat with load_pc=1, inc_pc=1, load_addr=0x3C4 -> prog_addr=0x3C4.
4. load_flags=1, alu_c=1, alu_z=0 during EXEC of opcode 0x3 -> the following edge shows c_flag=1, z_flag=0 with phase=0, so dec_addr=0011100 for the same opcode until the next fetch.
5. enable=0 for 5 cycles with inc_pc/load_flags toggling randomly -> no output changes; on re-enable the phase sequence continues from the held value.
6. Run a 4-instruction program (0x10, 0x2F, 0x8x jump to 0x000, ...) using the decode ROM model as the control source -> PC and dec_addr sequence match the golden trace cycle-for-cycle.
